// File: rtl/trng_word_collector_pkg.sv
// Shared types and default sizing for the TRNG word collector.
package trng_pkg;
  typedef enum logic {WAIT_A = 1'b0, WAIT_B = 1'b1} pair_st_e;

  localparam int DEF_WORD_W     = 8;
  localparam int DEF_SAMPLE_DIV = 4;
  localparam int DEF_REP_LIMIT  = 32;
endpackage

// File: rtl/trng_word_collector_vn_extractor.sv
// Sample divider, von Neumann pair extractor and repetition-count health test
// over the strobed raw entropy samples.
module vn_extractor
  import trng_pkg::*;
#(
  parameter int SAMPLE_DIV = DEF_SAMPLE_DIV,
  parameter int REP_LIMIT  = DEF_REP_LIMIT
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_hold,
  input  logic i_raw,
  output logic o_emit,
  output logic o_bit,
  output logic o_fail_trip
);
  localparam int DW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int RW = $clog2(REP_LIMIT + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SAMPLE_DIV - 1);
  localparam logic [RW-1:0] RUN_MAX  = RW'(REP_LIMIT);

  logic [DW-1:0] r_div;
  logic          w_strobe;
  pair_st_e      r_st, w_st_nxt;
  logic          r_a;
  logic [RW-1:0] r_run, w_run_nxt;
  logic          r_prev;

  assign w_strobe = (r_div == DIV_LAST);

  // Divider is free-running; health_clr deliberately leaves it alone.
  always_ff @(posedge clk) begin
    if (reset) r_div <= '0;
    else       r_div <= w_strobe ? '0 : r_div + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_st <= WAIT_A;
      r_a  <= 1'b0;
    end else begin
      r_st <= w_st_nxt;
      if (w_strobe && r_st == WAIT_A) r_a <= i_raw;
    end
  end

  always_comb begin
    w_st_nxt = r_st;
    if (i_clr || i_hold) w_st_nxt = WAIT_A;
    else if (w_strobe)   w_st_nxt = (r_st == WAIT_A) ? WAIT_B : WAIT_A;
  end

  always_comb begin
    o_emit = w_strobe && (r_st == WAIT_B) && (r_a != i_raw) && !i_clr && !i_hold;
    o_bit  = r_a;
  end

  // A zero run means no previous sample yet, so the first sample starts a run of one.
  always_comb begin
    if (r_run == '0 || i_raw != r_prev) w_run_nxt = RW'(1);
    else if (r_run == RUN_MAX)          w_run_nxt = r_run;
    else                                w_run_nxt = r_run + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_run  <= '0;
      r_prev <= 1'b0;
    end else if (i_clr) begin
      r_run  <= '0;
    end else if (w_strobe) begin
      r_run  <= w_run_nxt;
      r_prev <= i_raw;
    end
  end

  assign o_fail_trip = w_strobe && !i_clr && (w_run_nxt == RUN_MAX);
endmodule

// File: rtl/trng_word_collector.sv
// Packs von Neumann extracted bits into words, presents them on a valid/ready
// output register and keeps the sticky health-test failure flag.
module trng_word_collector
  import trng_pkg::*;
#(
  parameter int WORD_W     = DEF_WORD_W,
  parameter int SAMPLE_DIV = DEF_SAMPLE_DIV,
  parameter int REP_LIMIT  = DEF_REP_LIMIT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              raw_bit,
  output logic [WORD_W-1:0] rnd_data,
  output logic              rnd_valid,
  input  logic              rnd_ready,
  output logic              health_fail,
  input  logic              health_clr
);
  localparam int CW = $clog2(WORD_W + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(WORD_W);
  localparam logic [CW-1:0] CNT_LAST = CW'(WORD_W - 1);

  logic              w_emit_raw, w_bit, w_trip;
  logic              w_emit, w_accept, w_out_free;
  logic [WORD_W-1:0] w_word_nxt;
  logic [WORD_W-1:0] r_word, r_data;
  logic [CW-1:0]     r_cnt;
  logic              r_valid, r_fail;

  vn_extractor #(
    .SAMPLE_DIV(SAMPLE_DIV),
    .REP_LIMIT (REP_LIMIT)
  ) u_vn (
    .clk        (clk),
    .reset      (reset),
    .i_clr      (health_clr),
    .i_hold     (r_fail),
    .i_raw      (raw_bit),
    .o_emit     (w_emit_raw),
    .o_bit      (w_bit),
    .o_fail_trip(w_trip)
  );

  // A bit extracted on the tripping edge is already suspect, so drop it too.
  assign w_emit     = w_emit_raw && !w_trip;
  assign w_accept   = r_valid && rnd_ready;
  assign w_out_free = !r_valid || w_accept;
  assign w_word_nxt = {r_word[WORD_W-2:0], w_bit};

  always_ff @(posedge clk) begin
    if (reset) r_fail <= 1'b0;
    else       r_fail <= health_clr ? 1'b0 : (r_fail || w_trip);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_word  <= '0;
      r_cnt   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      if (w_accept) r_valid <= 1'b0;
      if (health_clr || r_fail || w_trip) begin
        r_word <= '0;
        r_cnt  <= '0;
      end else if (r_cnt == CNT_FULL) begin
        // Holding a finished word: further emits are discarded until it moves out.
        if (w_out_free) begin
          r_data  <= r_word;
          r_valid <= 1'b1;
          r_cnt   <= '0;
        end
      end else if (w_emit) begin
        if (r_cnt == CNT_LAST && w_out_free) begin
          r_data  <= w_word_nxt;
          r_valid <= 1'b1;
          r_cnt   <= '0;
        end else if (r_cnt == CNT_LAST) begin
          r_word  <= w_word_nxt;
          r_cnt   <= CNT_FULL;
        end else begin
          r_word  <= w_word_nxt;
          r_cnt   <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign rnd_data    = r_data;
  assign rnd_valid   = r_valid;
  assign health_fail = r_fail;
endmodule
